rr_arbiter2: RTL and testbench

RR_ARBITER2 -- requirements
Module: rr_arbiter2

---
 rtl/rr_arbiter2_pkg.sv | 13 +
 rtl/rr_arbiter2_if.sv | 44 ++++
 rtl/rr_arbiter2_mux2to1.sv | 12 +
 rtl/rr_arbiter2.sv | 109 ++++++++++
 tb/tb_rr_arbiter2.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter2_pkg.sv
// Shared types and defaults for the two-channel round-robin arbiter.
// Holds the FSM encoding and default parameter values.
package rr_arbiter2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter2_if.sv
// Bundle of the two input channels, the registered output and counters.
// master drives requests and out_ready; slave is the arbiter.
interface rr_arbiter2_if
    import rr_arbiter2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in0_valid, in0_data,
        input  in1_valid, in1_data,
        input  out_ready,
        output in0_ready, in1_ready,
        output sel,
        output out_valid, out_data, out_src,
        output cnt0, cnt1
    );

    modport master (
        output in0_valid, in0_data,
        output in1_valid, in1_data,
        output out_ready,
        input  in0_ready, in1_ready,
        input  sel,
        input  out_valid, out_data, out_src,
        input  cnt0, cnt1
    );

endinterface

// File: rtl/rr_arbiter2_mux2to1.sv
// Single-bit 2:1 mux used to build the arbiter data-select path.
// s=0 passes a, s=1 passes b.
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-channel round-robin arbiter feeding a one-entry output register.
// Ties go to the channel that did not win the last transfer.
module rr_arbiter2
    import rr_arbiter2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter2_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic             last_q;
    logic [WIDTH-1:0] data_q;
    logic             src_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic             can_load;
    logic             gnt;
    logic             xfer0;
    logic             xfer1;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    // With no request the grant parks on last, which also drives sel.
    always_comb begin
        gnt = last_q;
        unique case (1'b1)
            bus.in0_valid & bus.in1_valid:  gnt = ~last_q;
            bus.in1_valid & ~bus.in0_valid: gnt = 1'b1;
            bus.in0_valid & ~bus.in1_valid: gnt = 1'b0;
            default:                        gnt = last_q;
        endcase
    end

    assign can_load = (state_q == EMPTY) | bus.out_ready;
    assign xfer0    = can_load & bus.in0_valid & ~gnt;
    assign xfer1    = can_load & bus.in1_valid & gnt;
    assign xfer     = xfer0 | xfer1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2to1 u_mux (
            .a (bus.in0_data[i]),
            .b (bus.in1_data[i]),
            .s (gnt),
            .y (mux_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = FULL;
        end else if (bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            src_q  <= 1'b0;
            last_q <= 1'b1;
        end else if (xfer) begin
            data_q <= mux_data;
            src_q  <= gnt;
            last_q <= gnt;
        end
    end

    // Counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer0 && cnt0_q != CNT_MAX) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (xfer1 && cnt1_q != CNT_MAX) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign bus.in0_ready = xfer0;
    assign bus.in1_ready = xfer1;
    assign bus.sel       = gnt;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_rr_arbiter2.sv
// Directed bench for rr_arbiter2: an 8-bit/8-bit-counter instance
// and a 1-bit/2-bit-counter instance for mux and saturation cases.
module tb_rr_arbiter2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    rr_arbiter2_if #(.WIDTH(8), .CNT_W(8)) b8 ();
    rr_arbiter2_if #(.WIDTH(1), .CNT_W(2)) b1 ();

    rr_arbiter2 #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    rr_arbiter2 #(.WIDTH(1), .CNT_W(2)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        b8.in0_valid = 1'b0;
        b8.in1_valid = 1'b0;
        b8.in0_data  = '0;
        b8.in1_data  = '0;
        b8.out_ready = 1'b0;
        b1.in0_valid = 1'b0;
        b1.in1_valid = 1'b0;
        b1.in0_data  = '0;
        b1.in1_data  = '0;
        b1.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        vecs++;
        if (b8.out_valid !== 1'b0 || b8.out_data !== 8'h00
            || b8.out_src !== 1'b0) begin
            errs++;
            $display("FAIL rst_out got v=%0b d=%0h s=%0b exp 0/00/0",
                     b8.out_valid, b8.out_data, b8.out_src);
        end
        vecs++;
        if (b8.sel !== 1'b1 || b8.cnt0 !== 8'd0 || b8.cnt1 !== 8'd0) begin
            errs++;
            $display("FAIL rst_state got sel=%0b c0=%0d c1=%0d exp 1/0/0",
                     b8.sel, b8.cnt0, b8.cnt1);
        end
        rst_n = 1'b1;
        b8.in0_valid = 1'b1;
        b8.in0_data  = 8'hA5;
        tick();
        b8.in0_valid = 1'b0;
        vecs++;
        if (b8.out_valid !== 1'b1 || b8.out_data !== 8'hA5
            || b8.cnt0 !== 8'd1) begin
            errs++;
            $display("FAIL rst_load got v=%0b d=%0h c0=%0d exp 1/a5/1",
                     b8.out_valid, b8.out_data, b8.cnt0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (b8.out_valid !== 1'b0 || b8.out_data !== 8'h00
            || b8.cnt0 !== 8'd0 || b8.sel !== 1'b1) begin
            errs++;
            $display("FAIL rst_async got v=%0b d=%0h c0=%0d sel=%0b exp 0/00/0/1",
                     b8.out_valid, b8.out_data, b8.cnt0, b8.sel);
        end
        b8.in0_valid = 1'b1;
        b8.in0_data  = 8'h3C;
        tick();
        vecs++;
        if (b8.out_valid !== 1'b0 || b8.cnt0 !== 8'd0) begin
            errs++;
            $display("FAIL rst_nocount got v=%0b c0=%0d exp 0/0",
                     b8.out_valid, b8.cnt0);
        end
        drive_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        logic exp;
        do_reset();
        b8.in0_valid = 1'b1;
        b8.in1_valid = 1'b1;
        b8.in0_data  = 8'h00;
        b8.in1_data  = 8'h01;
        b8.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1);
            vecs++;
            if (b8.sel !== exp || b8.in0_ready !== ~exp
                || b8.in1_ready !== exp) begin
                errs++;
                $display("FAIL tie_grant[%0d] got sel=%0b r0=%0b r1=%0b exp sel=%0b",
                         i, b8.sel, b8.in0_ready, b8.in1_ready, exp);
            end
            tick();
            vecs++;
            if (b8.out_src !== exp || b8.out_data !== {7'd0, exp}
                || b8.out_valid !== 1'b1) begin
                errs++;
                $display("FAIL tie_out[%0d] got src=%0b d=%0h v=%0b exp src=%0b",
                         i, b8.out_src, b8.out_data, b8.out_valid, exp);
            end
        end
        b8.in0_valid = 1'b0;
        b8.in1_valid = 1'b0;
        vecs++;
        if (b8.cnt0 !== 8'd2 || b8.cnt1 !== 8'd2) begin
            errs++;
            $display("FAIL tie_cnt got c0=%0d c1=%0d exp 2/2",
                     b8.cnt0, b8.cnt1);
        end
        tick();
        vecs++;
        if (b8.out_valid !== 1'b0) begin
            errs++;
            $display("FAIL tie_drain got v=%0b exp 0", b8.out_valid);
        end
        tick();
        b8.in0_valid = 1'b1;
        b8.in1_valid = 1'b1;
        #1;
        vecs++;
        if (b8.sel !== 1'b0) begin
            errs++;
            $display("FAIL tie_idle_order got sel=%0b exp 0", b8.sel);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        b8.in1_valid = 1'b1;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b8.in1_data = 8'h30 + 8'(i);
            #1;
            vecs++;
            if (b8.in1_ready !== 1'b1 || b8.in0_ready !== 1'b0) begin
                errs++;
                $display("FAIL single_rdy[%0d] got r0=%0b r1=%0b exp 0/1",
                         i, b8.in0_ready, b8.in1_ready);
            end
            tick();
            vecs++;
            if (b8.out_src !== 1'b1 || b8.out_data !== 8'h30 + 8'(i)) begin
                errs++;
                $display("FAIL single_out[%0d] got src=%0b d=%0h exp 1/%0h",
                         i, b8.out_src, b8.out_data, 8'h30 + 8'(i));
            end
        end
        vecs++;
        if (b8.cnt1 !== 8'd3 || b8.cnt0 !== 8'd0) begin
            errs++;
            $display("FAIL single_cnt got c0=%0d c1=%0d exp 0/3",
                     b8.cnt0, b8.cnt1);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        b8.in0_valid = 1'b1;
        b8.in0_data  = 8'h5A;
        tick();
        b8.in0_data  = 8'h11;
        b8.in1_valid = 1'b1;
        b8.in1_data  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++;
            if (b8.in0_ready !== 1'b0 || b8.in1_ready !== 1'b0) begin
                errs++;
                $display("FAIL bp_rdy[%0d] got r0=%0b r1=%0b exp 0/0",
                         i, b8.in0_ready, b8.in1_ready);
            end
            tick();
            vecs++;
            if (b8.out_data !== 8'h5A || b8.out_valid !== 1'b1
                || b8.out_src !== 1'b0) begin
                errs++;
                $display("FAIL bp_hold[%0d] got d=%0h v=%0b src=%0b exp 5a/1/0",
                         i, b8.out_data, b8.out_valid, b8.out_src);
            end
        end
        b8.out_ready = 1'b1;
        #1;
        vecs++;
        if (b8.in1_ready !== 1'b1 || b8.in0_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_release got r0=%0b r1=%0b exp 0/1",
                     b8.in0_ready, b8.in1_ready);
        end
        tick();
        vecs++;
        if (b8.out_data !== 8'h22 || b8.out_src !== 1'b1
            || b8.out_valid !== 1'b1) begin
            errs++;
            $display("FAIL bp_b2b got d=%0h src=%0b v=%0b exp 22/1/1",
                     b8.out_data, b8.out_src, b8.out_valid);
        end
        b8.in0_valid = 1'b0;
        b8.in1_valid = 1'b0;
        tick();
        vecs++;
        if (b8.out_valid !== 1'b0 || b8.cnt0 !== 8'd1
            || b8.cnt1 !== 8'd1) begin
            errs++;
            $display("FAIL bp_end got v=%0b c0=%0d c1=%0d exp 0/1/1",
                     b8.out_valid, b8.cnt0, b8.cnt1);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp;
        do_reset();
        b1.in0_valid = 1'b1;
        b1.in0_data  = 1'b1;
        b1.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 2'(i + 1) : 2'd3;
            vecs++;
            if (b1.cnt0 !== exp || b1.out_valid !== 1'b1) begin
                errs++;
                $display("FAIL sat[%0d] got c0=%0d v=%0b exp %0d/1",
                         i, b1.cnt0, b1.out_valid, exp);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_mux();
        logic [2:0] cv;
        logic       exp;
        do_reset();
        b1.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cv = 3'(c);
            b1.in0_valid = ~cv[2];
            b1.in1_valid = cv[2];
            b1.in1_data  = cv[1];
            b1.in0_data  = cv[0];
            exp = cv[2] ? cv[1] : cv[0];
            #1;
            vecs++;
            if (b1.sel !== cv[2]) begin
                errs++;
                $display("FAIL mux_sel[%0d] got %0b exp %0b",
                         c, b1.sel, cv[2]);
            end
            tick();
            vecs++;
            if (b1.out_data !== exp || b1.out_src !== cv[2]) begin
                errs++;
                $display("FAIL mux_out[%0d] got d=%0b src=%0b exp %0b/%0b",
                         c, b1.out_data, b1.out_src, exp, cv[2]);
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_saturation();
        test_mux();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
